// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit core: opcode encoding, flag bundle
// and default datapath widths.
package cpu_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_XOR = 4'b0010,
    OP_AND = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRA = 4'b0101,
    OP_ROR = 4'b0110,
    OP_OR  = 4'b0111,
    OP_LW  = 4'b1000,
    OP_SW  = 4'b1001,
    OP_BEQ = 4'b1010,
    OP_BNE = 4'b1011,
    OP_BLT = 4'b1100,
    OP_JMP = 4'b1101,
    OP_LUI = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

endpackage

// File: rtl/flag_unit.sv
// Next-state Z/V/N and per-flag write enables for an
// executed instruction.
module flag_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] result,
  output flags_t            nxt,
  output flags_t            we
);

  localparam int MSB = DATA_W - 1;

  logic is_add;
  logic is_sub;
  logic is_zonly;
  logic add_ov;
  logic sub_ov;
  logic unused_lo;

  assign is_add   = (opcode == OP_ADD);
  assign is_sub   = (opcode == OP_SUB);
  assign is_zonly = (opcode == OP_XOR) || (opcode == OP_SLL) ||
                    (opcode == OP_SRA) || (opcode == OP_ROR);

  // Overflow only needs operand sign bits
  assign add_ov = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
  assign sub_ov = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);

  assign unused_lo = ^{a[MSB-1:0], b[MSB-1:0]};

  always_comb begin
    nxt   = '0;
    we    = '0;
    nxt.z = (result == '0);
    nxt.n = result[MSB];
    unique case (1'b1)
      is_add: begin
        we    = '1;
        nxt.v = add_ov;
      end
      is_sub: begin
        we    = '1;
        nxt.v = sub_ov;
      end
      is_zonly: we.z = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register; owns the Z/V/N flag register
// and the sticky halt indicator.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  input  logic [3:0]            ex_opcode_i,
  input  logic [DATA_W-1:0]     ex_a_i,
  input  logic [DATA_W-1:0]     ex_b_i,
  input  logic [DATA_W-1:0]     ex_result_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_regwrite_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_memwrite_i,
  input  logic [DATA_W-1:0]     ex_storedata_i,
  output logic                  mem_valid_o,
  output logic [3:0]            mem_opcode_o,
  output logic [DATA_W-1:0]     mem_result_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic                  mem_regwrite_o,
  output logic                  mem_memread_o,
  output logic                  mem_memwrite_o,
  output logic [DATA_W-1:0]     mem_storedata_o,
  output logic                  flag_z_o,
  output logic                  flag_v_o,
  output logic                  flag_n_o,
  output logic                  halted_o
);

  flags_t flags_q;
  flags_t flags_nxt;
  flags_t flags_we;
  logic   upd;

  flag_unit #(.DATA_W(DATA_W)) u_flag (
    .opcode (ex_opcode_i),
    .a      (ex_a_i),
    .b      (ex_b_i),
    .result (ex_result_i),
    .nxt    (flags_nxt),
    .we     (flags_we)
  );

  assign upd = ex_valid_i && !stall_i && !flush_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_o     <= 1'b0;
      mem_opcode_o    <= '0;
      mem_result_o    <= '0;
      mem_rd_o        <= '0;
      mem_regwrite_o  <= 1'b0;
      mem_memread_o   <= 1'b0;
      mem_memwrite_o  <= 1'b0;
      mem_storedata_o <= '0;
    end else if (flush_i) begin
      mem_valid_o     <= 1'b0;
      mem_opcode_o    <= '0;
      mem_result_o    <= '0;
      mem_rd_o        <= '0;
      mem_regwrite_o  <= 1'b0;
      mem_memread_o   <= 1'b0;
      mem_memwrite_o  <= 1'b0;
      mem_storedata_o <= '0;
    end else if (!stall_i) begin
      mem_valid_o     <= ex_valid_i;
      mem_opcode_o    <= ex_opcode_i;
      mem_result_o    <= ex_result_i;
      mem_rd_o        <= ex_rd_i;
      // R0 is hard-wired zero, never a write target
      mem_regwrite_o  <= ex_valid_i && ex_regwrite_i &&
                         (ex_rd_i != '0);
      mem_memread_o   <= ex_valid_i && ex_memread_i;
      mem_memwrite_o  <= ex_valid_i && ex_memwrite_i;
      mem_storedata_o <= ex_storedata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q  <= '0;
      halted_o <= 1'b0;
    end else if (upd) begin
      if (flags_we.z) flags_q.z <= flags_nxt.z;
      if (flags_we.v) flags_q.v <= flags_nxt.v;
      if (flags_we.n) flags_q.n <= flags_nxt.n;
      if (ex_opcode_i == OP_HLT) halted_o <= 1'b1;
    end
  end

  assign flag_z_o = flags_q.z;
  assign flag_v_o = flags_q.v;
  assign flag_n_o = flags_q.n;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed vector bench for ex_mem_stage: table of captures
// plus stall/flush/halt/reset sequences.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i;
  logic        ex_valid_i;
  logic [3:0]  ex_opcode_i;
  logic [15:0] ex_a_i, ex_b_i, ex_result_i, ex_storedata_i;
  logic [3:0]  ex_rd_i;
  logic        ex_regwrite_i, ex_memread_i, ex_memwrite_i;
  logic        mem_valid_o;
  logic [3:0]  mem_opcode_o;
  logic [15:0] mem_result_o, mem_storedata_o;
  logic [3:0]  mem_rd_o;
  logic        mem_regwrite_o, mem_memread_o, mem_memwrite_o;
  logic        flag_z_o, flag_v_o, flag_n_o, halted_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_opcode_i(ex_opcode_i),
    .ex_a_i(ex_a_i), .ex_b_i(ex_b_i),
    .ex_result_i(ex_result_i), .ex_rd_i(ex_rd_i),
    .ex_regwrite_i(ex_regwrite_i),
    .ex_memread_i(ex_memread_i),
    .ex_memwrite_i(ex_memwrite_i),
    .ex_storedata_i(ex_storedata_i),
    .mem_valid_o(mem_valid_o), .mem_opcode_o(mem_opcode_o),
    .mem_result_o(mem_result_o), .mem_rd_o(mem_rd_o),
    .mem_regwrite_o(mem_regwrite_o),
    .mem_memread_o(mem_memread_o),
    .mem_memwrite_o(mem_memwrite_o),
    .mem_storedata_o(mem_storedata_o),
    .flag_z_o(flag_z_o), .flag_v_o(flag_v_o),
    .flag_n_o(flag_n_o), .halted_o(halted_o)
  );

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [15:0] a, b, r;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    logic [15:0] sd;
    logic        e_rw, e_mr, e_mw;
    logic        e_z, e_v, e_n;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] rd,
                       input logic rw, input logic mr,
                       input logic mw, input logic [15:0] sd);
    ex_valid_i     = v;
    ex_opcode_i    = op;
    ex_a_i         = a;
    ex_b_i         = b;
    ex_result_i    = r;
    ex_rd_i        = rd;
    ex_regwrite_i  = rw;
    ex_memread_i   = mr;
    ex_memwrite_i  = mw;
    ex_storedata_i = sd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_flags(input string nm, input logic z,
                           input logic v, input logic n);
    chk({nm, "_zvn"}, {29'd0, flag_z_o, flag_v_o, flag_n_o},
        {29'd0, z, v, n});
  endtask

  function automatic vec_t mk(
      logic v, logic [3:0] op, logic [15:0] a, logic [15:0] b,
      logic [15:0] r, logic [3:0] rd, logic rw, logic mr,
      logic mw, logic [15:0] sd, logic e_rw, logic e_mr,
      logic e_mw, logic e_z, logic e_v, logic e_n);
    vec_t t;
    t.v = v; t.op = op; t.a = a; t.b = b; t.r = r; t.rd = rd;
    t.rw = rw; t.mr = mr; t.mw = mw; t.sd = sd;
    t.e_rw = e_rw; t.e_mr = e_mr; t.e_mw = e_mw;
    t.e_z = e_z; t.e_v = e_v; t.e_n = e_n;
    return t;
  endfunction

  initial begin
    // v op a b r rd rw mr mw sd | e_rw e_mr e_mw z v n
    vecs.push_back(mk(1, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'd3,
                      1, 0, 0, 16'h1111, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 4'd4,
                      1, 0, 0, 16'h2222, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'd3,
                      1, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'h8, 16'h0000, 16'h0000, 16'h0000, 4'd6,
                      1, 1, 0, 16'h0000, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'h2, 16'h00FF, 16'h00FF, 16'h0000, 4'd5,
                      1, 0, 0, 16'h3333, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 4'h0, 16'h0001, 16'h0001, 16'h0002, 4'd0,
                      1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h1, 16'h0000, 16'h0000, 16'h0000, 4'd2,
                      1, 1, 1, 16'h5555, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'h9, 16'h0010, 16'h0000, 16'h0010, 4'd0,
                      0, 0, 1, 16'hABCD, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'd9,
                      1, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'h5, 16'hFFFE, 16'h0001, 16'hFFFF, 4'd9,
                      1, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4'h6, 16'h0000, 16'h0004, 16'h0000, 4'd9,
                      1, 0, 0, 16'h0000, 1, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 4'h1, 16'h0003, 16'hFFFF, 16'h0004, 4'd1,
                      1, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 16'h8000, 16'h8000, 16'h0000, 4'd1,
                      1, 0, 0, 16'h0000, 1, 0, 0, 1, 1, 0));

    // Reset with garbage on every input
    rst_n = 1'b0;
    stall_i = 1'b1;
    flush_i = 1'b1;
    drive(1, 4'hF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'hF,
          1, 1, 1, 16'hFFFF);
    @(negedge clk);
    step();
    step();
    chk("rst_valid", {31'd0, mem_valid_o}, 0);
    chk("rst_opcode", {28'd0, mem_opcode_o}, 0);
    chk("rst_result", {16'd0, mem_result_o}, 0);
    chk("rst_rd", {28'd0, mem_rd_o}, 0);
    chk("rst_en", {29'd0, mem_regwrite_o, mem_memread_o,
                   mem_memwrite_o}, 0);
    chk("rst_sd", {16'd0, mem_storedata_o}, 0);
    chk_flags("rst", 0, 0, 0);
    chk("rst_halted", {31'd0, halted_o}, 0);

    // First capture after release
    rst_n = 1'b1;
    stall_i = 1'b0;
    flush_i = 1'b0;
    drive(1, 4'h0, 16'h0001, 16'h0002, 16'h0003, 4'd1,
          1, 0, 0, 16'h0000);
    step();
    chk("first_valid", {31'd0, mem_valid_o}, 1);
    chk("first_result", {16'd0, mem_result_o}, 32'h3);
    chk_flags("first", 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].r, vecs[i].rd, vecs[i].rw, vecs[i].mr,
            vecs[i].mw, vecs[i].sd);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, mem_valid_o},
          {31'd0, vecs[i].v});
      chk($sformatf("v%0d_op", i), {28'd0, mem_opcode_o},
          {28'd0, vecs[i].op});
      chk($sformatf("v%0d_res", i), {16'd0, mem_result_o},
          {16'd0, vecs[i].r});
      chk($sformatf("v%0d_rd", i), {28'd0, mem_rd_o},
          {28'd0, vecs[i].rd});
      chk($sformatf("v%0d_sd", i), {16'd0, mem_storedata_o},
          {16'd0, vecs[i].sd});
      chk($sformatf("v%0d_en", i),
          {29'd0, mem_regwrite_o, mem_memread_o, mem_memwrite_o},
          {29'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
      chk_flags($sformatf("v%0d", i),
                vecs[i].e_z, vecs[i].e_v, vecs[i].e_n);
      chk($sformatf("v%0d_halt", i), {31'd0, halted_o}, 0);
    end

    // Flags now Z=1 V=1 N=0; SLL with nonzero result
    drive(1, 4'h4, 16'h0001, 16'h0001, 16'h0002, 4'd7,
          1, 0, 0, 16'h0000);
    step();
    chk_flags("sll", 0, 1, 0);
    chk("sll_res", {16'd0, mem_result_o}, 32'h2);

    drive(1, 4'h1, 16'h0001, 16'h0001, 16'h0000, 4'd8,
          1, 0, 0, 16'h0000);
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("stall%0d_res", k), {16'd0, mem_result_o},
          32'h2);
      chk($sformatf("stall%0d_rd", k), {28'd0, mem_rd_o}, 32'd7);
      chk($sformatf("stall%0d_op", k), {28'd0, mem_opcode_o},
          32'h4);
      chk($sformatf("stall%0d_valid", k), {31'd0, mem_valid_o}, 1);
      chk_flags($sformatf("stall%0d", k), 0, 1, 0);
    end

    flush_i = 1'b1;
    step();
    chk("sflush_valid", {31'd0, mem_valid_o}, 0);
    chk("sflush_res", {16'd0, mem_result_o}, 0);
    chk("sflush_rd", {28'd0, mem_rd_o}, 0);
    chk("sflush_rw", {31'd0, mem_regwrite_o}, 0);
    chk_flags("sflush", 0, 1, 0);

    stall_i = 1'b0;
    flush_i = 1'b0;
    step();
    chk_flags("sub_after", 1, 0, 0);

    // Halt: flushed HLT ignored, real HLT sticky
    drive(1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 4'd0,
          0, 0, 0, 16'h0000);
    flush_i = 1'b1;
    step();
    chk("hlt_flush", {31'd0, halted_o}, 0);
    flush_i = 1'b0;
    step();
    chk("hlt_set", {31'd0, halted_o}, 1);
    chk("hlt_valid", {31'd0, mem_valid_o}, 1);
    for (int k = 0; k < 10; k++) begin
      drive(1, 4'h0, 16'(k), 16'h0001, 16'(k + 1), 4'd2,
            1, 0, 0, 16'h0000);
      step();
      chk($sformatf("hlt_keep%0d", k), {31'd0, halted_o}, 1);
      chk($sformatf("hlt_run%0d", k), {16'd0, mem_result_o},
          32'(k + 1));
    end

    rst_n = 1'b0;
    step();
    chk("hlt_rst", {31'd0, halted_o}, 0);
    chk("hlt_rst_valid", {31'd0, mem_valid_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
